falafel_mem_ctrl: RTL and testbench

- Memory-side endpoint sitting directly downstream of falafel_lsu.
- Consumes the LSU's valid/ready memory request stream (read, write, compare-and-swap) and executes each request atomically against a single-ported word array.
- Returns exactly one in-order response per request through a credit-bounded pipeline and response FIFO.
- Used as the backing store for allocator unit and system tests.

---
 rtl/falafel_pkg.sv | 28 ++
 rtl/falafel_mem_ctrl_if.sv | 27 ++
 rtl/falafel_fifo.sv | 49 ++++
 rtl/falafel_mem_ctrl.sv | 110 +++++++++++
 tb/tb_falafel_mem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel memory-side blocks.
package falafel_pkg;

   localparam int unsigned DATA_W     = 64;
   localparam int unsigned WORD_BYTES = DATA_W / 8;

   typedef enum logic [1:0] {
      MEM_READ,
      MEM_WRITE,
      MEM_CAS
   } mem_op_e;

   typedef struct packed {
      logic              is_write;
      logic              is_cas;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] cas_exp;
   } mem_req_t;

   // is_cas without is_write degrades to a plain read.
   function automatic mem_op_e decode_op(input logic is_write, input logic is_cas);
      if (!is_write) return MEM_READ;
      if (is_cas)    return MEM_CAS;
      return MEM_WRITE;
   endfunction

endpackage

// File: rtl/falafel_mem_ctrl_if.sv
// Request/response bus between falafel_lsu (master) and falafel_mem_ctrl (slave).
interface falafel_mem_ctrl_if #(
   parameter int unsigned DATA_W = falafel_pkg::DATA_W
);

   logic              req_val;
   logic              req_rdy;
   logic              req_is_write;
   logic              req_is_cas;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [DATA_W-1:0] req_cas_exp;
   logic              rsp_val;
   logic              rsp_rdy;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_val, req_is_write, req_is_cas, req_addr, req_data, req_cas_exp, rsp_rdy,
      input  req_rdy, rsp_val, rsp_data
   );

   modport slave (
      input  req_val, req_is_write, req_is_cas, req_addr, req_data, req_cas_exp, rsp_rdy,
      output req_rdy, rsp_val, rsp_data
   );

endinterface

// File: rtl/falafel_fifo.sv
// Circular FIFO with occupancy count; storage is not cleared by reset.
module falafel_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full, do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   // A push into a full FIFO is only legal when a pop frees the slot this cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointer/count update and storage write.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/falafel_mem_ctrl.sv
// Memory endpoint: executes read/write/CAS atomically at the accepting edge and returns
// in-order responses through a fixed-latency pipeline and a credit-bounded response FIFO.
module falafel_mem_ctrl #(
   parameter int unsigned DATA_W         = falafel_pkg::DATA_W,
   parameter int unsigned DEPTH_WORDS    = 1024,
   parameter int unsigned LATENCY        = 2,
   parameter int unsigned RSP_FIFO_DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   falafel_mem_ctrl_if.slave        mem,
   output logic                     err_o
);

   import falafel_pkg::*;

   localparam int unsigned ADDR_LSB = $clog2(WORD_BYTES);
   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W    = $clog2(RSP_FIFO_DEPTH + 1);

   mem_req_t          req;
   mem_op_e           op;
   logic [IDX_W-1:0]  idx;
   logic              oor, accept, push, pop, fifo_empty, mem_we, err_q;
   logic [DATA_W-1:0] rsp_d, fifo_head;
   logic [CNT_W-1:0]  inflight_q, fifo_count;

   logic [DATA_W-1:0] mem_q       [DEPTH_WORDS];
   logic              pipe_val_q  [LATENCY];
   logic [DATA_W-1:0] pipe_data_q [LATENCY];

   assign req = '{
      is_write: mem.req_is_write,
      is_cas:   mem.req_is_cas,
      addr:     mem.req_addr,
      data:     mem.req_data,
      cas_exp:  mem.req_cas_exp
   };

   assign op  = decode_op(req.is_write, req.is_cas);
   assign idx = req.addr[ADDR_LSB +: IDX_W];
   assign oor = (req.addr >= DATA_W'(DEPTH_WORDS * WORD_BYTES));

   // Credits come only from registered counts, so rdy never depends on rsp_rdy.
   assign mem.req_rdy = rst_ni &&
      (({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(RSP_FIFO_DEPTH));
   assign accept = mem.req_val && mem.req_rdy;
   assign push   = pipe_val_q[LATENCY-1];
   assign pop    = mem.rsp_val && mem.rsp_rdy;

   // Decode the request into response data and array write enable.
   always_comb begin
      rsp_d  = '0;
      mem_we = 1'b0;
      unique case (op)
         MEM_READ:  rsp_d = oor ? '0 : mem_q[idx];
         MEM_WRITE: mem_we = !oor;
         MEM_CAS: begin
            if (!oor) begin
               rsp_d  = mem_q[idx];
               mem_we = (mem_q[idx] == req.cas_exp);
            end
         end
         default: ;
      endcase
      mem_we = mem_we && accept;
   end

   // Word array; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[idx] <= req.data;
   end

   // Response pipeline, outstanding-request counter and sticky range error.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < LATENCY; k++) pipe_val_q[k] <= 1'b0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         pipe_val_q[0]  <= accept;
         pipe_data_q[0] <= rsp_d;
         for (int k = 1; k < LATENCY; k++) begin
            pipe_val_q[k]  <= pipe_val_q[k-1];
            pipe_data_q[k] <= pipe_data_q[k-1];
         end
         inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(push);
         if (accept && oor) err_q <= 1'b1;
      end
   end

   falafel_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RSP_FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (push),
      .wdata  (pipe_data_q[LATENCY-1]),
      .pop    (pop),
      .rdata  (fifo_head),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign mem.rsp_val  = !fifo_empty;
   assign mem.rsp_data = fifo_empty ? '0 : fifo_head;
   assign err_o        = err_q;

endmodule

// File: tb/tb_falafel_mem_ctrl.sv
// Directed and scoreboarded bench for falafel_mem_ctrl.
module tb_falafel_mem_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err;
   int   n_pass = 0;
   int   n_total = 0;

   falafel_mem_ctrl_if mem_if ();

   falafel_mem_ctrl #(
      .DATA_W         (64),
      .DEPTH_WORDS    (1024),
      .LATENCY        (2),
      .RSP_FIFO_DEPTH (4)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .mem    (mem_if),
      .err_o  (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Present one request at a negedge; returns at the negedge after it is accepted.
   task automatic send(input logic w, input logic c, input logic [63:0] a,
                       input logic [63:0] d, input logic [63:0] e, output bit ok);
      mem_if.req_is_write = w;
      mem_if.req_is_cas   = c;
      mem_if.req_addr     = a;
      mem_if.req_data     = d;
      mem_if.req_cas_exp  = e;
      mem_if.req_val      = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (mem_if.req_rdy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      mem_if.req_val = 1'b0;
      if (!ok) begin
         n_total++;
         $display("FAIL accept_timeout: addr %h got rdy=0 for 100 cycles, required acceptance", a);
      end
   endtask

   // Wait for a response, pop it, return its data.
   task automatic recv(output logic [63:0] d);
      bit seen = 1'b0;
      d = '1;
      for (int i = 0; i < 100; i++) begin
         if (mem_if.rsp_val) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (seen) begin
         d = mem_if.rsp_data;
         mem_if.rsp_rdy = 1'b1;
         @(negedge clk);
         mem_if.rsp_rdy = 1'b0;
      end else begin
         n_total++;
         $display("FAIL rsp_timeout: got no rsp_val in 100 cycles, required a response");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (mem_if.req_rdy !== 1'b0) $display("FAIL rst_rdy: got %b want 0", mem_if.req_rdy); else n_pass++;
      n_total++; if (mem_if.rsp_val !== 1'b0) $display("FAIL rst_val: got %b want 0", mem_if.rsp_val); else n_pass++;
      n_total++; if (mem_if.rsp_data !== 64'h0) $display("FAIL rst_data: got %h want 0", mem_if.rsp_data); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if (mem_if.rsp_val !== 1'b0) $display("FAIL post_rst_val: got %b want 0", mem_if.rsp_val); else n_pass++;
      n_total++; if (mem_if.rsp_data !== 64'h0) $display("FAIL post_rst_data: got %h want 0", mem_if.rsp_data); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL post_rst_err: got %b want 0", err); else n_pass++;
      n_total++; if (mem_if.req_rdy !== 1'b1) $display("FAIL post_rst_rdy: got %b want 1", mem_if.req_rdy); else n_pass++;
   endtask

   // Write then read 0x40 on consecutive edges; responses at t+2 and t+3.
   task automatic test_back_to_back();
      mem_if.rsp_rdy      = 1'b1;
      mem_if.req_is_write = 1'b1;
      mem_if.req_is_cas   = 1'b0;
      mem_if.req_addr     = 64'h40;
      mem_if.req_data     = 64'h1111;
      mem_if.req_cas_exp  = 64'h0;
      mem_if.req_val      = 1'b1;
      n_total++; if (mem_if.req_rdy !== 1'b1) $display("FAIL b2b_rdy: got %b want 1", mem_if.req_rdy); else n_pass++;
      @(negedge clk);  // edge t accepted the write
      mem_if.req_is_write = 1'b0;
      @(negedge clk);  // edge t+1 accepted the read
      mem_if.req_val = 1'b0;
      n_total++; if (mem_if.rsp_val !== 1'b0) $display("FAIL b2b_early: got val %b want 0", mem_if.rsp_val); else n_pass++;
      @(negedge clk);  // after edge t+2
      n_total++; if (mem_if.rsp_val !== 1'b1 || mem_if.rsp_data !== 64'h0)
         $display("FAIL b2b_wr_rsp: got val %b data %h want val 1 data 0", mem_if.rsp_val, mem_if.rsp_data);
      else n_pass++;
      @(negedge clk);  // after edge t+3
      n_total++; if (mem_if.rsp_val !== 1'b1 || mem_if.rsp_data !== 64'h1111)
         $display("FAIL b2b_rd_rsp: got val %b data %h want val 1 data 1111", mem_if.rsp_val, mem_if.rsp_data);
      else n_pass++;
      @(negedge clk);
      n_total++; if (mem_if.rsp_val !== 1'b0) $display("FAIL b2b_drain: got val %b want 0", mem_if.rsp_val); else n_pass++;
      mem_if.rsp_rdy = 1'b0;
   endtask

   task automatic test_cas();
      logic [63:0] exp_rsp [4];
      logic [63:0] d;
      bit ok;
      exp_rsp = '{64'h0, 64'h5, 64'h9, 64'h9};
      send(1'b1, 1'b0, 64'h80, 64'h5, 64'h0, ok);
      send(1'b1, 1'b1, 64'h80, 64'h9, 64'h5, ok);
      send(1'b1, 1'b1, 64'h80, 64'h7, 64'h5, ok);
      send(1'b0, 1'b0, 64'h80, 64'h0, 64'h0, ok);
      for (int i = 0; i < 4; i++) begin
         recv(d);
         n_total++; if (d !== exp_rsp[i]) $display("FAIL cas_rsp%0d: got %h want %h", i, d, exp_rsp[i]); else n_pass++;
      end
      send(1'b0, 1'b0, 64'h80, 64'h0, 64'h0, ok);
      recv(d);
      n_total++; if (d !== 64'h9) $display("FAIL cas_final: got %h want 9", d); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [63:0] d;
      bit ok;
      int acc = 0;
      bit saw_rdy = 1'b0;
      for (int k = 0; k < 6; k++) begin
         send(1'b1, 1'b0, 64'h200 + 64'(k * 8), 64'hA0 + 64'(k), 64'h0, ok);
         recv(d);
      end
      for (int k = 0; k < 4; k++) begin
         send(1'b0, 1'b0, 64'h200 + 64'(k * 8), 64'h0, 64'h0, ok);
         if (ok) acc++;
      end
      n_total++; if (acc !== 4) $display("FAIL bp_accepted: got %0d want 4", acc); else n_pass++;
      n_total++; if (mem_if.req_rdy !== 1'b0) $display("FAIL bp_rdy_drop: got %b want 0", mem_if.req_rdy); else n_pass++;
      mem_if.req_addr = 64'h220;
      mem_if.req_val  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (mem_if.req_rdy) saw_rdy = 1'b1;
         @(negedge clk);
      end
      mem_if.req_val = 1'b0;
      n_total++; if (saw_rdy !== 1'b0) $display("FAIL bp_stall: got rdy during full, want none"); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         recv(d);
         n_total++; if (d !== 64'hA0 + 64'(k)) $display("FAIL bp_rsp%0d: got %h want %h", k, d, 64'hA0 + 64'(k)); else n_pass++;
      end
      send(1'b0, 1'b0, 64'h220, 64'h0, 64'h0, ok);
      send(1'b0, 1'b0, 64'h228, 64'h0, 64'h0, ok);
      for (int k = 4; k < 6; k++) begin
         recv(d);
         n_total++; if (d !== 64'hA0 + 64'(k)) $display("FAIL bp_rsp%0d: got %h want %h", k, d, 64'hA0 + 64'(k)); else n_pass++;
      end
   endtask

   task automatic test_out_of_range();
      logic [63:0] d;
      bit ok;
      send(1'b1, 1'b0, 64'h0, 64'hDEAD, 64'h0, ok);
      recv(d);
      n_total++; if (err !== 1'b0) $display("FAIL oor_err_pre: got %b want 0", err); else n_pass++;
      send(1'b0, 1'b0, 64'h2000, 64'h0, 64'h0, ok);
      n_total++; if (err !== 1'b1) $display("FAIL oor_err_set: got %b want 1", err); else n_pass++;
      recv(d);
      n_total++; if (d !== 64'h0) $display("FAIL oor_rd_rsp: got %h want 0", d); else n_pass++;
      send(1'b1, 1'b0, 64'h2000, 64'hBEEF, 64'h0, ok);
      recv(d);
      send(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, ok);
      recv(d);
      n_total++; if (d !== 64'hDEAD) $display("FAIL oor_mem0: got %h want dead", d); else n_pass++;
      n_total++; if (err !== 1'b1) $display("FAIL oor_err_sticky: got %b want 1", err); else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] model [8];
      logic [63:0] expq [$];
      logic [63:0] d;
      bit ok;
      int got = 0;
      for (int k = 0; k < 8; k++) begin
         model[k] = {$urandom, $urandom};
         send(1'b1, 1'b0, 64'h300 + 64'(k * 8), model[k], 64'h0, ok);
         recv(d);
      end
      fork
         begin
            for (int n = 0; n < 200; n++) begin
               int op, k;
               logic [63:0] a, wd, e, old;
               op  = $urandom_range(0, 3);
               k   = $urandom_range(0, 7);
               a   = 64'h300 + 64'(k * 8) + 64'($urandom_range(0, 7));
               wd  = {$urandom, $urandom};
               e   = ($urandom_range(0, 1) == 1) ? model[k] : {$urandom, $urandom};
               old = model[k];
               send(op[1], op[0], a, wd, e, ok);
               if (ok) begin
                  case (op)
                     0, 1: expq.push_back(old);
                     2: begin expq.push_back(64'h0); model[k] = wd; end
                     default: begin expq.push_back(old); if (old == e) model[k] = wd; end
                  endcase
               end
               repeat ($urandom_range(0, 2)) @(negedge clk);
            end
         end
         begin
            bit prev_stall = 1'b0;
            logic [63:0] prev_data = '0;
            bit rr;
            for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
               if (prev_stall) begin
                  n_total++;
                  if (mem_if.rsp_val !== 1'b1 || mem_if.rsp_data !== prev_data)
                     $display("FAIL rnd_stable: got val %b data %h want val 1 data %h",
                              mem_if.rsp_val, mem_if.rsp_data, prev_data);
                  else n_pass++;
               end
               rr = ($urandom_range(0, 99) < 60);
               mem_if.rsp_rdy = rr;
               if (mem_if.rsp_val && rr) begin
                  n_total++;
                  if (expq.size() == 0) begin
                     $display("FAIL rnd_extra: got data %h want no response", mem_if.rsp_data);
                  end else begin
                     d = expq.pop_front();
                     if (mem_if.rsp_data !== d)
                        $display("FAIL rnd_data%0d: got %h want %h", got, mem_if.rsp_data, d);
                     else n_pass++;
                  end
                  got++;
               end
               prev_stall = mem_if.rsp_val && !rr;
               prev_data  = mem_if.rsp_data;
               @(negedge clk);
            end
            mem_if.rsp_rdy = 1'b0;
            n_total++;
            if (got != 200) $display("FAIL rnd_count: got %0d responses want 200", got); else n_pass++;
         end
      join
   endtask

   task automatic test_reset_mid();
      logic [63:0] d;
      bit ok;
      bit stale = 1'b0;
      send(1'b1, 1'b0, 64'h400, 64'hCAFE, 64'h0, ok);
      recv(d);
      for (int k = 0; k < 4; k++) send(1'b0, 1'b0, 64'h400, 64'h0, 64'h0, ok);
      n_total++; if (mem_if.rsp_val !== 1'b1) $display("FAIL mid_queued: got val %b want 1", mem_if.rsp_val); else n_pass++;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++; if (mem_if.req_rdy !== 1'b0) $display("FAIL mid_rst_rdy: got %b want 0", mem_if.req_rdy); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if (mem_if.rsp_val !== 1'b0) $display("FAIL mid_val: got %b want 0", mem_if.rsp_val); else n_pass++;
      n_total++; if (mem_if.req_rdy !== 1'b1) $display("FAIL mid_rdy: got %b want 1", mem_if.req_rdy); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else n_pass++;
      mem_if.rsp_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (mem_if.rsp_val) stale = 1'b1;
         @(negedge clk);
      end
      mem_if.rsp_rdy = 1'b0;
      n_total++; if (stale !== 1'b0) $display("FAIL mid_stale: got stale response want none"); else n_pass++;
      send(1'b0, 1'b0, 64'h400, 64'h0, 64'h0, ok);
      recv(d);
      n_total++; if (d !== 64'hCAFE) $display("FAIL mid_persist: got %h want cafe", d); else n_pass++;
   endtask

   initial begin
      mem_if.req_val      = 1'b0;
      mem_if.req_is_write = 1'b0;
      mem_if.req_is_cas   = 1'b0;
      mem_if.req_addr     = '0;
      mem_if.req_data     = '0;
      mem_if.req_cas_exp  = '0;
      mem_if.rsp_rdy      = 1'b0;
      test_reset();
      test_back_to_back();
      test_cas();
      test_backpressure();
      test_out_of_range();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
